// File: rtl/ped_traffic_controller.sv
// Two-phase NS/EW intersection controller with a pedestrian walk cycle across
// the NS phase. All outputs are registered decodes of the next state.
module ped_traffic_controller #(
    parameter int GREEN_TICKS   = 10,
    parameter int YELLOW_TICKS  = 3,
    parameter int ALL_RED_TICKS = 1,
    parameter int WALK_TICKS    = 6,
    parameter int FLASH_TICKS   = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       ped_button,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] walk_state,
    output logic       ped_pending
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_B     = 3'd5
    } state_t;

    localparam logic [2:0] LT_RED  = 3'b100;
    localparam logic [2:0] LT_YEL  = 3'b010;
    localparam logic [2:0] LT_GRN  = 3'b001;
    localparam logic [2:0] WK_WALK = 3'b100;
    localparam logic [2:0] WK_FLSH = 3'b010;
    localparam logic [2:0] WK_DONT = 3'b001;

    localparam logic [CNT_W-1:0] GREEN_LAST   = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(ALL_RED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_END     = CNT_W'(WALK_TICKS);
    localparam logic [CNT_W-1:0] FLASH_END    = CNT_W'(WALK_TICKS + FLASH_TICKS);

    if (GREEN_TICKS < WALK_TICKS + FLASH_TICKS) begin : g_bad_walk_timing
        $fatal(1, "GREEN_TICKS must cover WALK_TICKS + FLASH_TICKS");
    end
    if (GREEN_TICKS < 1 || YELLOW_TICKS < 1 || ALL_RED_TICKS < 1 ||
        GREEN_TICKS > (2 ** CNT_W) || YELLOW_TICKS > (2 ** CNT_W) ||
        ALL_RED_TICKS > (2 ** CNT_W) || (WALK_TICKS + FLASH_TICKS) >= (2 ** CNT_W)) begin : g_bad_duration
        $fatal(1, "durations must be at least 1 and fit in CNT_W");
    end

    state_t           state_q, state_d, nxt_s;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic             served_q, served_d;
    logic             pend_q, pend_d;
    logic             last_s, legal_s;
    logic [2:0]       ns_q, ns_d, ew_q, ew_d, walk_q, walk_d;

    // Next-state, elapsed counter, request latch and registered output decode
    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        served_d  = served_q;
        pend_d    = pend_q | ped_button;
        nxt_s     = RED_B;
        last_s    = 1'b0;
        legal_s   = 1'b1;
        ns_d      = LT_RED;
        ew_d      = LT_RED;
        walk_d    = WK_DONT;

        case (state_q)
            NS_GREEN:  begin last_s = (elapsed_q == GREEN_LAST);   nxt_s = NS_YELLOW; end
            NS_YELLOW: begin last_s = (elapsed_q == YELLOW_LAST);  nxt_s = RED_A;     end
            RED_A:     begin last_s = (elapsed_q == ALL_RED_LAST); nxt_s = EW_GREEN;  end
            EW_GREEN:  begin last_s = (elapsed_q == GREEN_LAST);   nxt_s = EW_YELLOW; end
            EW_YELLOW: begin last_s = (elapsed_q == YELLOW_LAST);  nxt_s = RED_B;     end
            RED_B:     begin last_s = (elapsed_q == ALL_RED_LAST); nxt_s = NS_GREEN;  end
            default:   begin last_s = 1'b0; nxt_s = RED_B; legal_s = 1'b0; end
        endcase

        if (!legal_s) begin
            state_d   = RED_B;
            elapsed_d = '0;
            served_d  = 1'b0;
        end else if (tick) begin
            if (last_s) begin
                state_d   = nxt_s;
                elapsed_d = '0;
                if (state_q == NS_GREEN) begin
                    served_d = 1'b0;
                end else if (state_q == RED_B && pend_q) begin
                    // a press on this very cycle is absorbed by the service now starting
                    served_d = 1'b1;
                    pend_d   = 1'b0;
                end else begin
                    served_d = served_q;
                end
            end else begin
                elapsed_d = elapsed_q + CNT_W'(1);
            end
        end else begin
            state_d = state_q;
        end

        case (state_d)
            NS_GREEN:  begin ns_d = LT_GRN; ew_d = LT_RED; end
            NS_YELLOW: begin ns_d = LT_YEL; ew_d = LT_RED; end
            EW_GREEN:  begin ns_d = LT_RED; ew_d = LT_GRN; end
            EW_YELLOW: begin ns_d = LT_RED; ew_d = LT_YEL; end
            default:   begin ns_d = LT_RED; ew_d = LT_RED; end
        endcase

        if (state_d == NS_GREEN && served_d) begin
            if (elapsed_d < WALK_END) begin
                walk_d = WK_WALK;
            end else if (elapsed_d < FLASH_END) begin
                walk_d = WK_FLSH;
            end else begin
                walk_d = WK_DONT;
            end
        end else begin
            walk_d = WK_DONT;
        end
    end

    // State, counter, latch and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RED_B;
            elapsed_q <= '0;
            served_q  <= 1'b0;
            pend_q    <= 1'b0;
            ns_q      <= LT_RED;
            ew_q      <= LT_RED;
            walk_q    <= WK_DONT;
        end else begin
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            served_q  <= served_d;
            pend_q    <= pend_d;
            ns_q      <= ns_d;
            ew_q      <= ew_d;
            walk_q    <= walk_d;
        end
    end

    assign ns_light    = ns_q;
    assign ew_light    = ew_q;
    assign walk_state  = walk_q;
    assign ped_pending = pend_q;

endmodule

// File: tb/tb_ped_traffic_controller.sv
// Directed bench for ped_traffic_controller: GREEN=8, YELLOW=2, ALL_RED=1,
// WALK=3, FLASH=2, tick every 4 clk unless a test holds it.
module tb_ped_traffic_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       ped_button = 1'b0;
    logic [2:0] ns_light, ew_light, walk_state;
    logic       ped_pending;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    ped_traffic_controller #(
        .GREEN_TICKS(8), .YELLOW_TICKS(2), .ALL_RED_TICKS(1),
        .WALK_TICKS(3), .FLASH_TICKS(2), .CNT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .ped_button(ped_button),
        .ns_light(ns_light), .ew_light(ew_light), .walk_state(walk_state),
        .ped_pending(ped_pending)
    );

    // Expected {ns, ew} after k ticks since reset; one full cycle is 22 ticks.
    function automatic logic [5:0] lights_at(input int k);
        int p;
        if (k <= 0) return 6'b100_100;
        p = (k - 1) % 22;
        if (p < 8)       return 6'b001_100;
        else if (p < 10) return 6'b010_100;
        else if (p < 11) return 6'b100_100;
        else if (p < 19) return 6'b100_001;
        else if (p < 21) return 6'b100_010;
        else             return 6'b100_100;
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic tick_once();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick = 1'b0;
        ped_button = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic press();
        ped_button = 1'b1;
        @(negedge clk);
        ped_button = 1'b0;
    endtask

    task automatic test_reset();
        ped_button = 1'b1;
        @(negedge clk);
        checks++;
        if ({ns_light, ew_light, walk_state, ped_pending} !== 10'b100_100_001_0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b",
                     {ns_light, ew_light, walk_state, ped_pending}, 10'b100_100_001_0);
        end
        do_reset();
        checks++;
        if ({ns_light, ew_light, walk_state, ped_pending} !== 10'b100_100_001_0) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b",
                     {ns_light, ew_light, walk_state, ped_pending}, 10'b100_100_001_0);
        end
    endtask

    task automatic test_free_run();
        do_reset();
        for (int k = 1; k <= 44; k++) begin
            tick_once();
            checks++;
            if ({ns_light, ew_light} !== lights_at(k)) begin
                errors++;
                $display("FAIL free_run_lights tick %0d: got %b expected %b", k, {ns_light, ew_light}, lights_at(k));
            end
            checks++;
            if ({walk_state, ped_pending} !== 4'b001_0) begin
                errors++;
                $display("FAIL free_run_walk tick %0d: got %b expected %b", k, {walk_state, ped_pending}, 4'b001_0);
            end
        end
    endtask

    task automatic test_ped_request();
        logic [2:0] exp_walk;
        do_reset();
        repeat (12) tick_once();
        press();
        checks++;
        if (ped_pending !== 1'b1) begin
            errors++;
            $display("FAIL req_latch: got %b expected %b", ped_pending, 1'b1);
        end
        for (int k = 13; k <= 22; k++) tick_once();
        checks++;
        if ({ns_light, ew_light, walk_state, ped_pending} !== 10'b100_100_001_1) begin
            errors++;
            $display("FAIL req_red_b: got %b expected %b",
                     {ns_light, ew_light, walk_state, ped_pending}, 10'b100_100_001_1);
        end
        for (int i = 0; i < 8; i++) begin
            tick_once();
            exp_walk = (i < 3) ? 3'b100 : ((i < 5) ? 3'b010 : 3'b001);
            checks++;
            if ({ns_light, walk_state, ped_pending} !== {3'b001, exp_walk, 1'b0}) begin
                errors++;
                $display("FAIL req_walk elapsed %0d: got %b expected %b", i,
                         {ns_light, walk_state, ped_pending}, {3'b001, exp_walk, 1'b0});
            end
        end
        tick_once();
        checks++;
        if ({ns_light, walk_state} !== 6'b010_001) begin
            errors++;
            $display("FAIL req_yellow: got %b expected %b", {ns_light, walk_state}, 6'b010_001);
        end
    endtask

    task automatic test_held_button();
        logic [2:0] exp_walk;
        do_reset();
        repeat (22) tick_once();
        ped_button = 1'b1;
        @(negedge clk);
        checks++;
        if (ped_pending !== 1'b1) begin
            errors++;
            $display("FAIL held_set: got %b expected %b", ped_pending, 1'b1);
        end
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        checks++;
        if ({ns_light, walk_state, ped_pending} !== 7'b001_100_0) begin
            errors++;
            $display("FAIL held_absorb: got %b expected %b", {ns_light, walk_state, ped_pending}, 7'b001_100_0);
        end
        @(negedge clk);
        ped_button = 1'b0;
        checks++;
        if (ped_pending !== 1'b1) begin
            errors++;
            $display("FAIL held_reset_after: got %b expected %b", ped_pending, 1'b1);
        end
        repeat (2) @(negedge clk);
        for (int i = 1; i < 8; i++) begin
            tick_once();
            exp_walk = (i < 3) ? 3'b100 : ((i < 5) ? 3'b010 : 3'b001);
            checks++;
            if ({walk_state, ped_pending} !== {exp_walk, 1'b1}) begin
                errors++;
                $display("FAIL held_walk elapsed %0d: got %b expected %b", i,
                         {walk_state, ped_pending}, {exp_walk, 1'b1});
            end
        end
    endtask

    task automatic test_press_in_flash();
        do_reset();
        press();
        tick_once();
        checks++;
        if ({ns_light, walk_state, ped_pending} !== 7'b001_100_0) begin
            errors++;
            $display("FAIL flash_entry: got %b expected %b", {ns_light, walk_state, ped_pending}, 7'b001_100_0);
        end
        repeat (4) tick_once();
        press();
        checks++;
        if ({walk_state, ped_pending} !== 4'b010_1) begin
            errors++;
            $display("FAIL flash_press: got %b expected %b", {walk_state, ped_pending}, 4'b010_1);
        end
        tick_once();
        checks++;
        if ({ns_light, walk_state} !== 6'b001_001) begin
            errors++;
            $display("FAIL flash_done: got %b expected %b", {ns_light, walk_state}, 6'b001_001);
        end
        repeat (16) tick_once();
        checks++;
        if ({ns_light, ew_light, walk_state, ped_pending} !== 10'b100_100_001_1) begin
            errors++;
            $display("FAIL flash_red_b: got %b expected %b",
                     {ns_light, ew_light, walk_state, ped_pending}, 10'b100_100_001_1);
        end
        tick_once();
        checks++;
        if ({ns_light, walk_state, ped_pending} !== 7'b001_100_0) begin
            errors++;
            $display("FAIL flash_reserved: got %b expected %b", {ns_light, walk_state, ped_pending}, 7'b001_100_0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press();
        tick_once();
        press();
        checks++;
        if ({ns_light, walk_state, ped_pending} !== 7'b001_100_1) begin
            errors++;
            $display("FAIL mid_setup: got %b expected %b", {ns_light, walk_state, ped_pending}, 7'b001_100_1);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ns_light, ew_light, walk_state, ped_pending} !== 10'b100_100_001_0) begin
            errors++;
            $display("FAIL mid_reset: got %b expected %b",
                     {ns_light, ew_light, walk_state, ped_pending}, 10'b100_100_001_0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tick_high();
        do_reset();
        tick = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            checks++;
            if ({ns_light, ew_light, walk_state} !== {lights_at(k), 3'b001}) begin
                errors++;
                $display("FAIL tick_high cycle %0d: got %b expected %b", k,
                         {ns_light, ew_light, walk_state}, {lights_at(k), 3'b001});
            end
        end
        tick = 1'b0;
        for (int c = 0; c < 100; c++) begin
            ped_button = (c == 50) ? 1'b1 : 1'b0;
            @(negedge clk);
            checks++;
            if ({ns_light, ew_light, walk_state} !== {lights_at(48), 3'b001}) begin
                errors++;
                $display("FAIL frozen cycle %0d: got %b expected %b", c,
                         {ns_light, ew_light, walk_state}, {lights_at(48), 3'b001});
            end
        end
        ped_button = 1'b0;
        checks++;
        if (ped_pending !== 1'b1) begin
            errors++;
            $display("FAIL frozen_latch: got %b expected %b", ped_pending, 1'b1);
        end
        for (int k = 49; k <= 53; k++) begin
            tick_once();
            checks++;
            if ({ns_light, ew_light} !== lights_at(k)) begin
                errors++;
                $display("FAIL resume tick %0d: got %b expected %b", k, {ns_light, ew_light}, lights_at(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_ped_request();
        test_held_button();
        test_press_in_flash();
        test_reset_mid();
        test_tick_high();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
